// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - Philips I2S serial transmitter for 15-bit unsigned stereo samples
// Ports:
//   clock  - system clock, all logic on the rising edge
//   reset  - asynchronous active-low reset
//   left   - 15-bit unsigned left sample (midscale 0x4000), captured on load
//   right  - 15-bit unsigned right sample (midscale 0x4000), captured on load
//   sck    - I2S bit clock, period 2*DIV system clocks
//   ws     - word select, 0 = left slot, 1 = right slot
//   sd     - serial data, MSB first
//   load   - one-clock pulse on the edge where left/right are captured
//   mclk   - DAC master clock at clock/2, present only when I2S_MCLK_EN is defined
module i2s_tx #(
  parameter int DIV = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] left,
  input  logic [14:0] right,
  output logic        sck,
  output logic        ws,
  output logic        sd,
  output logic        load
`ifdef I2S_MCLK_EN
  ,
  output logic        mclk
`endif
);

  localparam logic [7:0] DCNT_MAX = 8'(DIV - 1);

  logic [7:0]  dcnt;
  logic [4:0]  bcnt;
  logic [31:0] sh;

  logic        tick;
  logic        fall;
  logic [4:0]  bcnt_nxt;
  logic [31:0] sh_nxt;
  logic        ws_nxt;
  logic        load_nxt;

  assign tick = (dcnt == DCNT_MAX);
  // sck is about to go high->low: this is where all serial outputs change
  assign fall = tick & sck;

  // Data output is the top of the shift register, so the first bit of a
  // frame appears on the very edge that captures the samples.
  assign sd = sh[31];

  always_comb begin
    bcnt_nxt = bcnt;
    sh_nxt   = sh;
    ws_nxt   = ws;
    load_nxt = 1'b0;
    if (fall) begin
      bcnt_nxt = bcnt + 5'd1;
      // ws switches one bit ahead of each slot's MSB (Philips alignment)
      ws_nxt   = (bcnt_nxt >= 5'd15) && (bcnt_nxt <= 5'd30);
      if (bcnt == 5'd31) begin
        // Offset-binary to two's complement: invert the top bit, then
        // left-justify into 16 bits with a zero LSB.
        sh_nxt   = {~left[14], left[13:0], 1'b0, ~right[14], right[13:0], 1'b0};
        load_nxt = 1'b1;
      end else begin
        sh_nxt = {sh[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dcnt <= 8'd0;
      sck  <= 1'b0;
      bcnt <= 5'd31;
      sh   <= 32'd0;
      ws   <= 1'b0;
      load <= 1'b0;
    end else begin
      dcnt <= tick ? 8'd0 : dcnt + 8'd1;
      if (tick) begin
        sck <= ~sck;
      end
      bcnt <= bcnt_nxt;
      sh   <= sh_nxt;
      ws   <= ws_nxt;
      load <= load_nxt;
    end
  end

`ifdef I2S_MCLK_EN
  // Free-running clock/2, deliberately unrelated to the sck phase
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mclk <= 1'b0;
    end else begin
      mclk <= ~mclk;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - self-checking bench for i2s_tx at DIV=8 and DIV=2
module tb_i2s_tx;

  localparam int DIV_A = 8;
  localparam int DIV_B = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] left_v  [2];
  logic [14:0] right_v [2];
  wire  [1:0]  sck_v;
  wire  [1:0]  ws_v;
  wire  [1:0]  sd_v;
  wire  [1:0]  load_v;
`ifdef I2S_MCLK_EN
  wire  [1:0]  mclk_v;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [14:0] l;
    logic [14:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t vecs [5];

  always #5 clock = ~clock;

  i2s_tx #(.DIV(DIV_A)) u_a (
    .clock (clock),
    .reset (reset),
    .left  (left_v[0]),
    .right (right_v[0]),
    .sck   (sck_v[0]),
    .ws    (ws_v[0]),
    .sd    (sd_v[0]),
    .load  (load_v[0])
`ifdef I2S_MCLK_EN
    ,
    .mclk  (mclk_v[0])
`endif
  );

  i2s_tx #(.DIV(DIV_B)) u_b (
    .clock (clock),
    .reset (reset),
    .left  (left_v[1]),
    .right (right_v[1]),
    .sck   (sck_v[1]),
    .ws    (ws_v[1]),
    .sd    (sd_v[1]),
    .load  (load_v[1])
`ifdef I2S_MCLK_EN
    ,
    .mclk  (mclk_v[1])
`endif
  );

  function automatic int div_of(input int idx);
    return (idx == 0) ? DIV_A : DIV_B;
  endfunction

  // Expected DAC word: sample minus midscale, times two, as 16-bit two's complement
  function automatic logic [15:0] conv(input logic [14:0] s);
    int v;
    v = (int'(s) - 32'h4000) * 2;
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // Advance to the next load pulse; n = clocks waited
  task automatic wait_load(input int idx, output int n);
    int bound;
    bound = 128 * div_of(idx) + 8;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!load_v[idx] && n < bound);
    if (!load_v[idx]) fail($sformatf("load_timeout: no load in %0d clocks, required a load", n));
  endtask

  // Advance to the next sck rising edge; sd/ws must not move on it
  task automatic next_rise(input int idx);
    logic ps, psd, pws;
    int   n;
    ps  = sck_v[idx];
    psd = sd_v[idx];
    pws = ws_v[idx];
    n   = 0;
    forever begin
      @(negedge clock);
      n++;
      if (sck_v[idx] && !ps) begin
        check("sd_stable_at_rise", 32'(sd_v[idx]), 32'(psd));
        check("ws_stable_at_rise", 32'(ws_v[idx]), 32'(pws));
        break;
      end
      if (n > 4 * div_of(idx)) begin
        fail($sformatf("sck_timeout: no rising edge in %0d clocks", n));
        break;
      end
      ps  = sck_v[idx];
      psd = sd_v[idx];
      pws = ws_v[idx];
    end
  endtask

  // Called at a load negedge: collects 32 bits on sck rising edges and
  // checks the ws pattern. Optionally rewrites left at bit chg_at.
  task automatic capture(input int idx, input int chg_at, input logic [14:0] chg_val,
                         output logic [15:0] lw, output logic [15:0] rw);
    logic [31:0] bits;
    bits = 32'd0;
    for (int k = 0; k < 32; k++) begin
      next_rise(idx);
      bits = {bits[30:0], sd_v[idx]};
      check($sformatf("ws_bit%0d", k), 32'(ws_v[idx]), 32'((k >= 15 && k <= 30) ? 1 : 0));
      if (k == chg_at) left_v[idx] = chg_val;
    end
    lw = bits[31:16];
    rw = bits[15:0];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  // DAC model scoreboard: random samples every frame, words recovered by
  // ws transitions and compared with what was driven at each load.
  task automatic run_sb(input int idx, input int nframes);
    logic [16:0] expq [$];
    logic [15:0] sreg;
    logic        ps, pws;
    int          bc, loads, words, n, budget;
    left_v[idx]  = 15'($urandom);
    right_v[idx] = 15'($urandom);
    do_reset();
    sreg = 16'd0; ps = 1'b0; pws = 1'b0;
    bc = 0; loads = 0; words = 0; n = 0;
    budget = (nframes + 2) * 64 * div_of(idx);
    while (words < 2 * nframes && n < budget) begin
      @(negedge clock);
      n++;
      if (load_v[idx] && loads < nframes) begin
        expq.push_back({1'b0, conv(left_v[idx])});
        expq.push_back({1'b1, conv(right_v[idx])});
        loads++;
        left_v[idx]  = 15'($urandom);
        right_v[idx] = 15'($urandom);
      end
      if (sck_v[idx] && !ps) begin
        sreg = {sreg[14:0], sd_v[idx]};
        bc++;
        if (ws_v[idx] != pws) begin
          if (bc >= 16) begin
            if (expq.size() == 0) fail($sformatf("sb_unexpected_word: got 0x%0h, required none", sreg));
            else check($sformatf("sb_word_div%0d", div_of(idx)), 32'({pws, sreg}), 32'(expq.pop_front()));
            words++;
          end
          bc = 0;
        end
        pws = ws_v[idx];
      end
      ps = sck_v[idx];
    end
    if (words < 2 * nframes) fail($sformatf("sb_timeout: %0d words, required %0d", words, 2 * nframes));
  endtask

  initial begin
    int          n, ra, la, rb, lb;
    logic [15:0] lw, rw;

    vecs[0] = '{15'h4000, 15'h4000, 16'h0000, 16'h0000};
    vecs[1] = '{15'h7FFF, 15'h0000, 16'h7FFE, 16'h8000};
    vecs[2] = '{15'h0000, 15'h7FFF, 16'h8000, 16'h7FFE};
    vecs[3] = '{15'h4001, 15'h3FFF, 16'h0002, 16'hFFFE};
    vecs[4] = '{15'h1234, 15'h5678, 16'hA468, 16'h2CF0};

    reset = 1'b0;
    left_v[0] = 15'h1234; right_v[0] = 15'h4000;
    left_v[1] = 15'h4000; right_v[1] = 15'h4000;
    repeat (3) @(negedge clock);
    check("rst_sck",  32'(sck_v),  32'd0);
    check("rst_ws",   32'(ws_v),   32'd0);
    check("rst_sd",   32'(sd_v),   32'd0);
    check("rst_load", 32'(load_v), 32'd0);
`ifdef I2S_MCLK_EN
    check("rst_mclk", 32'(mclk_v), 32'd0);
`endif

    // Startup timing from reset release
    reset = 1'b1;
    ra = 0; la = 0; rb = 0; lb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (sck_v[0] && ra == 0) ra = i;
      if (sck_v[1] && rb == 0) rb = i;
      if (load_v[1] && lb == 0) lb = i;
      if (load_v[0] && la == 0) begin
        la = i;
        check("first_sd_msb", 32'(sd_v[0]), 32'd1);
      end
    end
    check("first_rise_div8", 32'(ra), 32'd8);
    check("first_load_div8", 32'(la), 32'd16);
    check("first_rise_div2", 32'(rb), 32'd2);
    check("first_load_div2", 32'(lb), 32'd4);
    wait_load(0, n);
    wait_load(0, n);
    check("load_period_div8", 32'(n), 32'd512);
    wait_load(1, n);
    wait_load(1, n);
    check("load_period_div2", 32'(n), 32'd128);

    // Directed sample vectors
    for (int v = 0; v < 5; v++) begin
      left_v[0]  = vecs[v].l;
      right_v[0] = vecs[v].r;
      wait_load(0, n);
      capture(0, -1, 15'h0, lw, rw);
      check($sformatf("vec%0d_left", v),  32'(lw), 32'(vecs[v].el));
      check($sformatf("vec%0d_right", v), 32'(rw), 32'(vecs[v].er));
    end

    // Left changes mid-frame: only the following frame sees it
    left_v[0] = 15'h7FFF; right_v[0] = 15'h4000;
    wait_load(0, n);
    capture(0, 5, 15'h0000, lw, rw);
    check("midchg_cur_left", 32'(lw), 32'h7FFE);
    wait_load(0, n);
    capture(0, -1, 15'h0, lw, rw);
    check("midchg_next_left", 32'(lw), 32'h8000);

    // Reset asserted at bcnt=20 while sck, ws and sd are all high
    left_v[0] = 15'h4000; right_v[0] = 15'h7FFF;
    wait_load(0, n);
    for (int k = 0; k <= 20; k++) next_rise(0);
    check("pre_rst_sck", 32'(sck_v[0]), 32'd1);
    check("pre_rst_ws",  32'(ws_v[0]),  32'd1);
    check("pre_rst_sd",  32'(sd_v[0]),  32'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("async_rst_sck",  32'(sck_v),  32'd0);
    check("async_rst_ws",   32'(ws_v),   32'd0);
    check("async_rst_sd",   32'(sd_v),   32'd0);
    check("async_rst_load", 32'(load_v), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_hold_load", 32'(load_v), 32'd0);
    end
    reset = 1'b1;
    la = 0; lb = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clock);
      if (load_v[0] && la == 0) la = i;
      if (load_v[1] && lb == 0) lb = i;
`ifdef I2S_MCLK_EN
      check("mclk_toggle", 32'(mclk_v[0]), 32'(i & 1));
`endif
    end
    check("rst_reload_div8", 32'(la), 32'd16);
    check("rst_reload_div2", 32'(lb), 32'd4);

    // Random scoreboard at both dividers
    run_sb(0, 4);
    run_sb(1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
